// File: rtl/tpu_matmul_ctrl_pkg.sv
// rtl/tpu_matmul_ctrl_pkg.sv - shared types and constants for the TPU MatMul controller
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mm_state_t;

    localparam logic [15:0] TPU_BASE_A      = 16'h0100;
    localparam logic [15:0] TPU_BASE_B      = 16'h0200;
    localparam logic [15:0] TPU_BASE_C      = 16'h0300;
    localparam logic [15:0] TPU_ADDR_START  = 16'h0400;
    localparam logic [15:0] TPU_ADDR_STATUS = 16'h0408;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    // Skewed systolic wavefront: DIM to fill, DIM to drain, DIM-2 overlap.
    function automatic int matmul_cycles(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/tpu_matmul_ctrl_mmio_decode.sv
// rtl/tpu_matmul_ctrl_mmio_decode.sv - combinational MMIO window decode and row/half extraction
module tpu_mmio_decode
    import tpu_pkg::*;
#(
    parameter int               DIM        = 8,
    parameter int               ADDRW      = 16,
    parameter logic [ADDRW-1:0] BASE_A     = ADDRW'(TPU_BASE_A),
    parameter logic [ADDRW-1:0] BASE_B     = ADDRW'(TPU_BASE_B),
    parameter logic [ADDRW-1:0] BASE_C     = ADDRW'(TPU_BASE_C),
    parameter logic [ADDRW-1:0] ADDR_START = ADDRW'(TPU_ADDR_START)
) (
    input  logic                    req,
    input  logic [ADDRW-1:0]        addr,
    output logic                    hit_a,
    output logic                    hit_b,
    output logic                    hit_c,
    output logic                    hit_start,
    output logic [$clog2(DIM)-1:0]  a_row,
    output logic [$clog2(DIM)-1:0]  c_row,
    output logic                    c_half
);

    localparam int RW = $clog2(DIM);

    localparam logic [ADDRW-1:0] A_LAST = BASE_A + ADDRW'(DIM * DIM - 1);
    localparam logic [ADDRW-1:0] B_LAST = BASE_B + ADDRW'(DIM * DIM - 1);
    localparam logic [ADDRW-1:0] C_LAST = BASE_C + ADDRW'(2 * DIM * DIM - 1);

    assign hit_a     = req && (addr >= BASE_A) && (addr <= A_LAST);
    assign hit_b     = req && (addr >= BASE_B) && (addr <= B_LAST);
    assign hit_c     = req && (addr >= BASE_C) && (addr <= C_LAST);
    assign hit_start = req && (addr == ADDR_START);

    // A rows are DIM bytes apart; C rows are 2*DIM bytes, split into two DIM-byte halves.
    assign a_row  = addr[RW +: RW];
    assign c_row  = addr[RW + 1 +: RW];
    assign c_half = addr[RW];

endmodule

// File: rtl/tpu_matmul_ctrl.sv
// rtl/tpu_matmul_ctrl.sv - MMIO decoder and MatMul sequencer; TPU_CTRL_STATUS_EN adds sticky done/err status bits
module tpu_matmul_ctrl
    import tpu_pkg::*;
#(
    parameter int               DIM        = 8,
    parameter int               ADDRW      = 16,
    parameter int               DATAW      = 64,
    parameter logic [ADDRW-1:0] BASE_A     = ADDRW'(TPU_BASE_A),
    parameter logic [ADDRW-1:0] BASE_B     = ADDRW'(TPU_BASE_B),
    parameter logic [ADDRW-1:0] BASE_C     = ADDRW'(TPU_BASE_C),
    parameter logic [ADDRW-1:0] ADDR_START = ADDRW'(TPU_ADDR_START)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    r_w,
    input  logic [ADDRW-1:0]        addr,
    output logic                    wr_en_a,
    output logic                    wr_en_b,
    output logic                    wr_en_c,
    output logic [$clog2(DIM)-1:0]  a_row,
    output logic [$clog2(DIM)-1:0]  c_row,
    output logic                    c_half,
    output logic                    sa_en,
    output logic                    mem_b_en,
    output logic                    busy,
    output logic                    done,
    output logic [DATAW-1:0]        status_data
);

    localparam int               MM_CYCLES = matmul_cycles(DIM);
    localparam int               CNTW      = $clog2(MM_CYCLES);
    localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(MM_CYCLES - 1);

    logic w_hit_a;
    logic w_hit_b;
    logic w_hit_c;
    logic w_hit_start;
    logic w_start;

    mm_state_t       r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_sa_en;
    logic            r_busy;
    logic            r_done;

    tpu_mmio_decode #(
        .DIM        (DIM),
        .ADDRW      (ADDRW),
        .BASE_A     (BASE_A),
        .BASE_B     (BASE_B),
        .BASE_C     (BASE_C),
        .ADDR_START (ADDR_START)
    ) u_decode (
        .req       (req),
        .addr      (addr),
        .hit_a     (w_hit_a),
        .hit_b     (w_hit_b),
        .hit_c     (w_hit_c),
        .hit_start (w_hit_start),
        .a_row     (a_row),
        .c_row     (c_row),
        .c_half    (c_half)
    );

    assign w_start = w_hit_start && r_w;

    // Host writes into the operand/result windows are locked out for the whole compute window.
    assign wr_en_a  = w_hit_a && r_w && !r_busy;
    assign wr_en_b  = w_hit_b && r_w && !r_busy;
    assign wr_en_c  = w_hit_c && r_w && !r_busy;

    assign sa_en    = r_sa_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_b_en = wr_en_b || r_sa_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sa_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_sa_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // Starts seen here are ignored; the window length is fixed once launched.
                    r_cnt <= r_cnt + CNTW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                        r_sa_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sa_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TPU_CTRL_STATUS_EN
    logic w_status_rd;
    logic w_err_set;
    logic r_done_sticky;
    logic r_err;

    assign w_status_rd = req && !r_w && (addr == ADDRW'(TPU_ADDR_STATUS));
    assign w_err_set   = r_busy && r_w && (w_hit_a || w_hit_b || w_hit_c || w_hit_start);

    // A status read clears both bits, but an event landing in the same cycle must not be lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_sticky <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (r_done)
                r_done_sticky <= 1'b1;
            else if (w_status_rd)
                r_done_sticky <= 1'b0;
            if (w_err_set)
                r_err <= 1'b1;
            else if (w_status_rd)
                r_err <= 1'b0;
        end
    end
`endif

    always_comb begin
        status_data          = '0;
        status_data[ST_BUSY] = r_busy;
`ifdef TPU_CTRL_STATUS_EN
        status_data[ST_DONE] = r_done_sticky;
        status_data[ST_ERR]  = r_err;
`endif
    end

endmodule

// File: tb/tb_tpu_matmul_ctrl.sv
// tb/tb_tpu_matmul_ctrl.sv - self-checking bench for tpu_matmul_ctrl against a cycle-window reference model
module tb_tpu_matmul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        wr_en_a, wr_en_b, wr_en_c, c_half, sa_en, mem_b_en, busy, done;
    logic [2:0]  a_row, c_row;
    logic [63:0] status_data;

    tpu_matmul_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .r_w         (r_w),
        .addr        (addr),
        .wr_en_a     (wr_en_a),
        .wr_en_b     (wr_en_b),
        .wr_en_c     (wr_en_c),
        .a_row       (a_row),
        .c_row       (c_row),
        .c_half      (c_half),
        .sa_en       (sa_en),
        .mem_b_en    (mem_b_en),
        .busy        (busy),
        .done        (done),
        .status_data (status_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int rs      = -1000;
    bit m_ds    = 1'b0;
    bit m_err   = 1'b0;

    logic [13:0] exp_vec;
    logic [63:0] exp_status;
    logic [13:0] obs;
    assign obs = {wr_en_a, wr_en_b, wr_en_c, sa_en, mem_b_en, busy, done, a_row, c_row, c_half};

    function automatic bit in_win(input int a, input int base, input int size);
        return (a >= base) && (a < base + size);
    endfunction

    task automatic model_reset();
        rs    = -1000;
        m_ds  = 1'b0;
        m_err = 1'b0;
    endtask

    // Applies one MMIO cycle; the model says a run started at cycle rs owns cycles rs+1..rs+22 and pulses done at rs+23.
    task automatic apply(input bit q, input bit w, input int a);
        bit busy_m, done_m, wa, wb, wc, st, srd;
        @(posedge clk);
        #1;
        req  = q;
        r_w  = w;
        addr = a[15:0];
        cyc++;
        busy_m = (cyc > rs) && (cyc <= rs + 22);
        done_m = (cyc == rs + 23);
        wa = q && w && in_win(a, 'h100, 64);
        wb = q && w && in_win(a, 'h200, 64);
        wc = q && w && in_win(a, 'h300, 128);
        st = q && w && (a == 'h400);
        srd = q && !w && (a == 'h408);
        exp_vec = {wa && !busy_m, wb && !busy_m, wc && !busy_m, busy_m,
                   (wb && !busy_m) || busy_m, busy_m, done_m,
                   3'((a / 8) % 8), 3'((a / 16) % 8), 1'((a / 8) % 2)};
        exp_status = 64'd0;
        exp_status[0] = busy_m;
`ifdef TPU_CTRL_STATUS_EN
        exp_status[1] = m_ds;
        exp_status[2] = m_err;
`endif
        if (st && !busy_m) rs = cyc;
        if (srd) begin
            m_ds  = 1'b0;
            m_err = 1'b0;
        end
        if (done_m) m_ds = 1'b1;
        if (busy_m && (wa || wb || wc || st)) m_err = 1'b1;
        @(negedge clk);
    endtask

    function automatic int rand_addr();
        case ($urandom_range(0, 5))
            0: return 'h100 + $urandom_range(0, 63);
            1: return 'h200 + $urandom_range(0, 63);
            2: return 'h300 + $urandom_range(0, 127);
            3: return 'h408;
            4: return $urandom_range(0, 'h5FF);
            default: return 'h140 + $urandom_range(0, 'hBF);
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (obs !== 14'd0 || status_data !== 64'd0) begin
            fails++;
            $display("FAIL reset outputs got=%b/%h exp=0/0", obs, status_data);
        end
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_writes();
        int dir [3] = '{'h108, 'h238, 'h378};
        foreach (dir[i]) begin
            apply(1'b1, 1'b1, dir[i]);
            vectors++;
            if (obs !== exp_vec || status_data !== exp_status) begin
                fails++;
                $display("FAIL writes addr=%h got=%b/%h exp=%b/%h", dir[i], obs, status_data, exp_vec, exp_status);
            end
        end
        for (int i = 0; i < 40; i++) begin
            int a;
            a = rand_addr();
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a);
            vectors++;
            if (obs !== exp_vec || status_data !== exp_status) begin
                fails++;
                $display("FAIL rand_access addr=%h got=%b/%h exp=%b/%h", a, obs, status_data, exp_vec, exp_status);
            end
        end
    endtask

    task automatic test_matmul();
        apply(1'b1, 1'b1, 'h400);
        for (int i = 0; i < 26; i++) begin
            if (i != 0) apply(1'b0, 1'b0, 0);
            vectors++;
            if (obs !== exp_vec || status_data !== exp_status) begin
                fails++;
                $display("FAIL matmul step=%0d got=%b/%h exp=%b/%h", i, obs, status_data, exp_vec, exp_status);
            end
        end
    endtask

    task automatic test_lockout();
        logic [2:0] want [2];
`ifdef TPU_CTRL_STATUS_EN
        want[0] = 3'b110;
`else
        want[0] = 3'b000;
`endif
        want[1] = 3'b000;
        for (int t = 0; t <= 25; t++) begin
            if (t == 0 || t == 5)        apply(1'b1, 1'b1, 'h400);
            else if (t == 6)             apply(1'b1, 1'b1, 'h100);
            else if (t >= 24)            apply(1'b1, 1'b0, 'h408);
            else                         apply(1'b0, 1'b0, 0);
            vectors++;
            if (obs !== exp_vec || status_data !== exp_status) begin
                fails++;
                $display("FAIL lockout t=%0d got=%b/%h exp=%b/%h", t, obs, status_data, exp_vec, exp_status);
            end
            if (t >= 24) begin
                vectors++;
                if (status_data[2:0] !== want[t-24]) begin
                    fails++;
                    $display("FAIL status_read%0d got=%b exp=%b", t - 23, status_data[2:0], want[t-24]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        for (int t = 0; t <= 10; t++) begin
            apply(t == 0, t == 0, (t == 0) ? 'h400 : 0);
            vectors++;
            if (obs !== exp_vec) begin
                fails++;
                $display("FAIL pre_reset t=%0d got=%b exp=%b", t, obs, exp_vec);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sa_en, busy, done, mem_b_en} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset got=%b exp=0000", {sa_en, busy, done, mem_b_en});
        end
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int t = 0; t < 32; t++) begin
            apply(t == 4, t == 4, (t == 4) ? 'h400 : 0);
            vectors++;
            if (obs !== exp_vec || status_data !== exp_status) begin
                fails++;
                $display("FAIL post_reset t=%0d got=%b/%h exp=%b/%h", t, obs, status_data, exp_vec, exp_status);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t <= 47; t++) begin
            if (t == 0 || t == 23) apply(1'b1, 1'b1, 'h400);
            else if (t == 24)      apply(1'b1, 1'b0, 'h300);
            else if (t == 25)      apply(1'b1, 1'b0, 'h5FF);
            else                   apply(1'b0, 1'b0, 0);
            vectors++;
            if (obs !== exp_vec || status_data !== exp_status) begin
                fails++;
                $display("FAIL back_to_back t=%0d got=%b/%h exp=%b/%h", t, obs, status_data, exp_vec, exp_status);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int r, a;
            bit q, w;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                q = 1'b1; w = 1'b1; a = 'h400;
            end else if (r < 16) begin
                q = 1'b1; w = 1'b0; a = 'h408;
            end else begin
                q = 1'($urandom_range(0, 3) != 0);
                w = 1'($urandom_range(0, 1));
                a = rand_addr();
            end
            apply(q, w, a);
            vectors++;
            if (obs !== exp_vec || status_data !== exp_status) begin
                fails++;
                $display("FAIL random i=%0d q=%0b w=%0b addr=%h got=%b/%h exp=%b/%h",
                         i, q, w, a, obs, status_data, exp_vec, exp_status);
            end
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_matmul();
        test_lockout();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
